// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, default result-FIFO depth and function codes.
package alu_pkg;
  localparam int ALU_W = 8;
  localparam int ALU_DEPTH = 4;
  localparam int FW = 3;
  localparam logic [FW-1:0] FN_ADD = 3'd0;
  localparam logic [FW-1:0] FN_SUB = 3'd1;
  localparam logic [FW-1:0] FN_AND = 3'd2;
  localparam logic [FW-1:0] FN_OR = 3'd3;
  localparam logic [FW-1:0] FN_XOR = 3'd4;
  localparam logic [FW-1:0] FN_PASS = 3'd5;
endpackage

// File: rtl/hex_seg7.sv
// hex_seg7: 4-bit hex digit to active-low 7-segment pattern (bit 0 = segment a).
module hex_seg7 (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7f;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'ha: seg = 7'h08;
      4'hb: seg = 7'h03;
      4'hc: seg = 7'h46;
      4'hd: seg = 7'h21;
      4'he: seg = 7'h06;
      default: seg = 7'h0e;
    endcase
  end
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word fall-through queue of ALU results with B-operand feedback and stall counter.
// Define ALU_FIFO_HEX_EN to add HEX0/HEX1 seven-segment views of the head entry.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = ALU_DEPTH,
  parameter int W = ALU_W
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_result,
  input  logic [FW-1:0] in_func,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [FW-1:0] out_func,
  output logic [$clog2(DEPTH):0] count,
  output logic [3:0]    reg_b,
  output logic [7:0]    stall_cnt
`ifdef ALU_FIFO_HEX_EN
  ,
  output logic [6:0]    HEX0,
  output logic [6:0]    HEX1
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] data_mem [DEPTH];
  logic [FW-1:0] func_mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic push, pop;
  assign in_ready = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_data = out_valid ? data_mem[rptr] : '0;
  assign out_func = out_valid ? func_mem[rptr] : '0;
  // storage needs no reset: reads are masked whenever the queue is empty
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      data_mem[wptr] <= in_result;
      func_mem[wptr] <= in_func;
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // feedback and stall statistics track the handshake even when clear drops the entry
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      reg_b <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) reg_b <= in_result[3:0];
      if (in_valid && !in_ready && stall_cnt != 8'hff) stall_cnt <= stall_cnt + 8'd1;
    end
  end
`ifdef ALU_FIFO_HEX_EN
  logic [6:0] seg0, seg1;
  hex_seg7 u_hex0 (.hex(out_data[3:0]), .seg(seg0));
  hex_seg7 u_hex1 (.hex(out_data[7:4]), .seg(seg1));
  assign HEX0 = out_valid ? seg0 : 7'h7f;
  assign HEX1 = out_valid ? seg1 : 7'h7f;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed scenarios plus random traffic against a queue-based reference model.
module tb_alu_result_fifo;
  localparam int DEPTH = 4;
  typedef struct packed {logic [2:0] f; logic [7:0] d;} ent_t;
  logic clock = 0, resetn = 0, in_valid = 0, clear = 0, out_ready = 0;
  logic [7:0] in_result = 0;
  logic [2:0] in_func = 0;
  logic in_ready, out_valid;
  logic [7:0] out_data, stall_cnt;
  logic [2:0] out_func, count;
  logic [3:0] reg_b;
`ifdef ALU_FIFO_HEX_EN
  logic [6:0] HEX0, HEX1;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
`endif
  alu_result_fifo dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_func(in_func), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_func(out_func), .count(count),
    .reg_b(reg_b), .stall_cnt(stall_cnt)
`ifdef ALU_FIFO_HEX_EN
    , .HEX0(HEX0), .HEX1(HEX1)
`endif
  );
  always #5 clock = ~clock;
  int checks = 0, failures = 0;
  ent_t q[$];
  logic [3:0] m_regb = 0;
  int m_stall = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    int n = q.size();
    ent_t h = n != 0 ? q[0] : '0;
    chk("count", 32'(count), 32'(n));
    chk("in_ready", 32'(in_ready), 32'(n != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("out_data", 32'(out_data), 32'(h.d));
    chk("out_func", 32'(out_func), 32'(h.f));
    chk("reg_b", 32'(reg_b), 32'(m_regb));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`ifdef ALU_FIFO_HEX_EN
    chk("hex0", 32'(HEX0), 32'(n != 0 ? seg_tab[h.d[3:0]] : 7'h7f));
    chk("hex1", 32'(HEX1), 32'(n != 0 ? seg_tab[h.d[7:4]] : 7'h7f));
`endif
  endtask
  task automatic cyc(bit v, logic [7:0] d, logic [2:0] f, bit rdy, bit clr);
    bit full, do_push, do_pop;
    in_valid = v; in_result = d; in_func = f; out_ready = rdy; clear = clr;
    @(negedge clock);
    check_all();
    @(posedge clock);
    full = q.size() == DEPTH;
    do_push = v && !full;
    do_pop = rdy && q.size() != 0;
    if (do_push) m_regb = d[3:0];
    if (v && full && m_stall < 255) m_stall++;
    if (clr) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{f: f, d: d});
    end
    #1;
  endtask
  task automatic drain();
    while (q.size() != 0) cyc(0, 0, 0, 1, 0);
  endtask
  initial begin
    logic [7:0] vals [4] = '{8'ha1, 8'hb2, 8'hc3, 8'hd4};
    repeat (2) @(posedge clock);
    #1 check_all();
    @(negedge clock) resetn = 1;
    #6;
    cyc(1, 8'h12, 3'd1, 0, 0);
    chk("r034_data", 32'(out_data), 32'h12);
    chk("r034_func", 32'(out_func), 32'd1);
    chk("r034_count", 32'(count), 32'd1);
    chk("r034_regb", 32'(reg_b), 32'h2);
    drain();
    for (int i = 0; i < 4; i++) cyc(1, vals[i], 3'(i), 0, 0);
    chk("r035_count", 32'(count), 32'd4);
    chk("r035_ready", 32'(in_ready), 32'd0);
    repeat (3) cyc(1, 8'hee, 3'd5, 0, 0);
    chk("r035_stall", 32'(stall_cnt), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("r035_order", 32'(out_data), 32'(vals[i]));
      cyc(0, 0, 0, 1, 0);
    end
    cyc(1, 8'h11, 3'd0, 0, 0);
    cyc(1, 8'h22, 3'd1, 0, 0);
    cyc(1, 8'h55, 3'd2, 1, 0);
    chk("r036_count", 32'(count), 32'd2);
    cyc(0, 0, 0, 1, 0);
    chk("r036_third", 32'(out_data), 32'h55);
    drain();
    cyc(1, 8'h30, 3'd3, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h40 + i), 3'(i % 6), 1, 0);
    chk("r037_head", 32'(out_data), 32'h49);
    drain();
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h60 + i), 3'd4, 0, 0);
    cyc(1, 8'h77, 3'd0, 0, 1);
    chk("r038_count", 32'(count), 32'd0);
    chk("r038_valid", 32'(out_valid), 32'd0);
    chk("r038_data", 32'(out_data), 32'd0);
    chk("r038_regb", 32'(reg_b), 32'h7);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h80 + i), 3'd0, 0, 0);
    repeat (260) cyc(1, 8'h99, 3'd1, 0, 0);
    chk("stall_sat", 32'(stall_cnt), 32'd255);
    drain();
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 5)),
          1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
    cyc(1, 8'hab, 3'd2, 0, 0);
    cyc(1, 8'hcd, 3'd3, 0, 0);
    #2 resetn = 0;
    #1;
    chk("r039_valid", 32'(out_valid), 32'd0);
    chk("r039_count", 32'(count), 32'd0);
    chk("r039_ready", 32'(in_ready), 32'd1);
    chk("r039_data", 32'(out_data), 32'd0);
`ifdef ALU_FIFO_HEX_EN
    chk("r039_hex0", 32'(HEX0), 32'h7f);
    chk("r039_hex1", 32'(HEX1), 32'h7f);
`endif
    q.delete();
    m_regb = 0;
    m_stall = 0;
    in_valid = 0;
    @(negedge clock) check_all();
    resetn = 1;
    #6;
    cyc(1, 8'h3c, 3'd5, 0, 0);
    cyc(0, 0, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries (power of two, 2..16).
REQ-002 Parameter: W, 8, result data width (matches ALU output width).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clock  in  1  rising-edge clock.
REQ-005 Port: resetn  in  1  asynchronous active-low reset.
REQ-006 Port: in_valid  in  1  upstream ALU result valid.
REQ-007 Port: in_ready  out  1  block can accept a result this cycle.
REQ-008 Port: in_result  in  W  ALU result byte.
REQ-009 Port: in_func  in  3  ALU function code that produced in_result.
REQ-010 Port: clear  in  1  synchronous flush of queued entries.
REQ-011 Port: out_valid  out  1  head entry valid.
REQ-012 Port: out_ready  in  1  downstream consumes head entry.
REQ-013 Port: out_data  out  W  head entry result.
REQ-014 Port: out_func  out  3  head entry function code.
REQ-015 Port: count  out  $clog2(DEPTH)+1  entries held.
REQ-016 Port: reg_b  out  4  low nibble of last accepted result (ALU B-operand feedback).
REQ-017 Port: stall_cnt  out  8  saturating count of back-pressured cycles.

Function
REQ-018 Push SHALL occur on a rising edge when in_valid && in_ready; pop when out_valid && out_ready.
REQ-019 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on out_ready (full + pop same cycle: no push).
REQ-020 out_valid SHALL equal (count != 0); out_data/out_func SHALL show the head entry combinationally (first-word fall-through).
REQ-021 Push-to-out_valid latency SHALL be 1 cycle; no same-cycle bypass when empty.
REQ-022 Simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; entries SHALL exit in acceptance order.
REQ-024 When out_valid is 0, out_data and out_func SHALL hold 0.
REQ-025 reg_b SHALL update to in_result[3:0] on every push and hold otherwise.
REQ-026 stall_cnt SHALL increment on each cycle with in_valid && !in_ready, saturating at 255.
REQ-027 clear SHALL zero count and both pointers next edge, taking priority over same-cycle push/pop; reg_b and stall_cnt SHALL be unaffected.

Reset
REQ-028 While resetn is 0: count=0, pointers=0, out_valid=0, out_data=0, out_func=0, reg_b=0, stall_cnt=0, in_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-030 With ALU_FIFO_HEX_EN defined, ports HEX0, HEX1 (7 bits each, active-low segments) SHALL show out_data[3:0] and out_data[7:4]; blank (all 1) when out_valid is 0.
REQ-031 Without ALU_FIFO_HEX_EN, HEX0/HEX1 ports and the decoders SHALL be absent; all other behaviour identical.

Structure
REQ-032 A shared package alu_pkg SHALL hold W, default DEPTH, function-code width (3) and the six function-code constants (0..5).
REQ-033 One sub-module hex_seg7 (4-bit in, 7-bit active-low out) SHALL be instantiated twice, only under ALU_FIFO_HEX_EN.

Verification
REQ-034 Reset, then push 0x12/func 1 with out_ready=0 -> next cycle out_valid=1, out_data=0x12, out_func=1, count=1, reg_b=0x2.
REQ-035 Push 0xA1,0xB2,0xC3,0xD4 (out_ready=0) -> count=4, in_ready=0; hold in_valid 3 more cycles -> stall_cnt=3; pop all -> order A1,B2,C3,D4.
REQ-036 count=2, push 0x55 and pop same cycle -> count stays 2, 0x55 emerges third.
REQ-037 Push/pop 10 entries continuously at count=1..3 -> pointer wrap verified, sequence intact.
REQ-038 count=3, assert clear with push 0x77 -> next cycle count=0, out_valid=0, out_data=0, reg_b=0x7.
REQ-039 Drop resetn mid-stream between edges -> out_valid=0, count=0 immediately; with ALU_FIFO_HEX_EN, HEX0=HEX1=7'h7F.
